prod_acc: RTL

Framed accumulator placed directly downstream of the 4-bit array multiplier `mul_4`. It accepts a stream of 8-bit products over a valid/ready handshake and sums the products of one frame. A frame is closed by a last flag or a length limit. It then presents the frame sum, the beat count and an overflow flag on a registered valid/ready output, holding them until the consumer takes them.

---
 rtl/prod_acc.sv | 100 ++++++++++
 1 files changed

// File: rtl/prod_acc.sv
// Framed accumulator for mul_4 products; closes a frame on in_last or at MAX_LEN beats.
// Optional build macro PROD_ACC_SAT_EN: saturate the frame sum on overflow instead of wrapping.
module prod_acc #(
    parameter int PW      = 8,
    parameter int ACC_W   = 12,
    parameter int MAX_LEN = 16,
    localparam int CW     = $clog2(MAX_LEN) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PW-1:0]    in_p,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [CW-1:0]    out_cnt,
    output logic             out_ovf
);

    // state | meaning
    // ACC   | accepting beats of the current frame
    // HOLD  | frame result pending on the output registers
    typedef enum logic {ACC, HOLD} state_t;

    state_t           state, state_nxt;
    logic [ACC_W-1:0] acc, acc_upd;
    logic [CW-1:0]    cnt, cnt_upd;
    logic             ovf, ovf_upd;
    logic [ACC_W:0]   sum_ext;
    logic             accept, close;

    assign in_ready  = (state == ACC);
    assign out_valid = (state == HOLD);

    always_comb begin
        sum_ext = (ACC_W+1)'(acc) + (ACC_W+1)'(in_p);
        ovf_upd = ovf | sum_ext[ACC_W];
        cnt_upd = cnt + CW'(1);
`ifdef PROD_ACC_SAT_EN
        // once overflowed, the sum pins at full scale for the rest of the frame
        acc_upd = ovf_upd ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
        acc_upd = sum_ext[ACC_W-1:0];
`endif
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        close     = 1'b0;
        case (state)
            ACC: begin
                if (in_valid) begin
                    accept = 1'b1;
                    close  = in_last || (cnt_upd == CW'(MAX_LEN));
                    if (close) state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) state_nxt = ACC;
            end
            default: state_nxt = ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACC;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= '0;
            cnt     <= '0;
            ovf     <= 1'b0;
            out_sum <= '0;
            out_cnt <= '0;
            out_ovf <= 1'b0;
        end else if (accept) begin
            if (close) begin
                out_sum <= acc_upd;
                out_cnt <= cnt_upd;
                out_ovf <= ovf_upd;
                acc     <= '0;
                cnt     <= '0;
                ovf     <= 1'b0;
            end else begin
                acc <= acc_upd;
                cnt <= cnt_upd;
                ovf <= ovf_upd;
            end
        end
    end

endmodule
